pb_imem_loader: RTL and testbench
=================================

Name: pb_imem_loader

Overview:
- System-clock-domain consumer of the JTAG load-port write stream: loadAddr/loadData/wEn, already brought into clk_i domain as a single-cycle pulse.
- Buffers writes in a small FIFO and drives them onto the instruction-memory write port with a req/gnt handshake.
- Holds the rv32i core in hold/reset for the whole programming session, then issues a clean core reset on completion.

Parameters:
- ADDR_W, globalAddress_width (pb_pack), memory address width
- DATA_W, data_width (pb_pack), memory data width
- FIFO_DEPTH, 4, buffered writes; power of two, >=2
- IDLE_TIMEOUT, 64, clk_i cycles with FIFO empty and no new write before the session closes
- RST_CYCLES, 8, cycles cpu_rst_o is held high after the session

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- ld_valid_i  in  1  one-cycle write pulse from the synchronized TAP load port
- ld_addr_i  in  ADDR_W  write address, valid with ld_valid_i
- ld_data_i  in  DATA_W  write data, valid with ld_valid_i
- mem_req_o  out  1  memory write request
- mem_addr_o  out  ADDR_W  memory write address
- mem_data_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepts a write this cycle when mem_req_o & mem_gnt_i
- cpu_hold_o  out  1  core stall during the session
- cpu_rst_o  out  1  core reset pulse after the session
- busy_o  out  1  state != IDLE
- ovf_o  out  1  sticky flag: a write was dropped
- wcount_o  out  16  words written to memory this session, saturating at 0xFFFF
- checksum_o  out  DATA_W  see Optional Feature

Behaviour:
- Reset (async, rst_i=1): state IDLE, FIFO empty, timer 0.
  - mem_req_o=0, cpu_hold_o=0, cpu_rst_o=0, busy_o=0, ovf_o=0, wcount_o=0, checksum_o=0.
  - mem_addr_o/mem_data_o=0.
- FIFO push: a push happens on ld_valid_i when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise the write is dropped and ovf_o is set. ovf_o clears only on reset.
- FIFO pop: on mem_req_o & mem_gnt_i.
  - mem_req_o = FIFO not empty (in LOAD/DRAIN).
  - mem_addr_o/mem_data_o = FIFO head; stable while req is high and gnt is low.
- Latency: an ld_valid_i in cycle N gives mem_req_o in N+1 (registered FIFO, first-word not fall-through).
- FSM: IDLE, LOAD, DRAIN, RELEASE.
  - IDLE: on ld_valid_i go to LOAD; that word is pushed; wcount_o and checksum_o clear to 0 in the same cycle.
  - LOAD: cpu_hold_o=1.
    - Timer counts when FIFO empty and no ld_valid_i; otherwise it resets to 0.
    - Timer reaching IDLE_TIMEOUT-1 → DRAIN.
  - DRAIN: cpu_hold_o=1.
    - If FIFO empty → RELEASE.
    - If ld_valid_i arrives, it is pushed and the state returns to LOAD with timer 0.
  - RELEASE: cpu_hold_o=1, cpu_rst_o=1 for exactly RST_CYCLES cycles → IDLE.
    - ld_valid_i in RELEASE is dropped and sets ovf_o.
- wcount_o increments per accepted memory write and saturates.
- Reset mid-session: all state is discarded immediately; queued FIFO writes are lost; cpu_hold_o and cpu_rst_o drop asynchronously.

Optional Feature:
- Macro: PB_LOADER_CHECKSUM_EN
- Defined: checksum_o = 32-bit-style wrap-around sum (DATA_W bits) of every data word accepted by memory this session. It is cleared on session start and frozen after the session for readback.
- Undefined: checksum_o tied to 0 and no adder logic synthesized.

Decomposition:
- pb_pack additions:
  - typedef enum loader_state_t {IDLE, LOAD, DRAIN, RELEASE}
  - constants LOADER_FIFO_DEPTH=4, LOADER_IDLE_TIMEOUT=64, LOADER_RST_CYCLES=8
- Sub-module pb_sync_fifo.
  - Parameters: width, depth.
  - Ports: push/pop/full/empty/head.
  - Pointers one bit wider than log2(depth) for full/empty detection.
- The FSM, timer and counters stay in pb_imem_loader.

Test Plan:
- Single write: ld_valid_i with addr 0x10, data 0xDEADBEEF, gnt tied 1.
  - mem_req_o high 1 cycle later with the same addr/data.
  - wcount_o=1, checksum_o=0xDEADBEEF (with the macro).
  - After 64 idle cycles: cpu_rst_o high for 8 cycles, then busy_o=0.
- Backpressure: gnt=0 while 4 writes arrive.
  - FIFO full, no drop.
  - A 5th write with gnt=0 sets ovf_o=1.
  - Releasing gnt drains exactly 4 writes in order.
- Full plus simultaneous pop: FIFO full, gnt=1 and ld_valid_i in the same cycle.
  - Write accepted, ovf_o stays 0, order preserved.
- Re-entry during DRAIN: a write arriving in the DRAIN cycle returns the FSM to LOAD with timer 0.
  - cpu_rst_o does not pulse until a further 64 idle cycles.
- Write during RELEASE: dropped, ovf_o=1, no memory write, state returns to IDLE after 8 cycles.
- Reset mid-session: assert rst_i with 3 words queued.
  - All outputs go to reset values asynchronously and no further mem_req_o occurs.

Source files
------------

// File: rtl/pb_imem_loader_pkg.sv
// rtl/pb_imem_loader_pkg.sv - shared widths, loader constants and state encoding
package pb_imem_loader_pkg;

    localparam int globalAddress_width = 16;
    localparam int data_width          = 32;

    localparam int LOADER_FIFO_DEPTH   = 4;
    localparam int LOADER_IDLE_TIMEOUT = 64;
    localparam int LOADER_RST_CYCLES   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/pb_imem_loader_sync_fifo.sv
// rtl/pb_imem_loader_sync_fifo.sv - registered FIFO, head read combinationally from storage
module pb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes wrapped-full from empty when the indices match.
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign head  = mem[rdPtr[AW-1:0]];

    // Storage and pointers; a push into a full FIFO is only legal alongside a pop,
    // which frees the slot being overwritten after its old value has been read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr[AW-1:0]] <= pushData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pb_imem_loader.sv
// rtl/pb_imem_loader.sv - JTAG load stream to imem writer with core hold/reset; PB_LOADER_CHECKSUM_EN adds checksum_o
module pb_imem_loader
    import pb_imem_loader_pkg::*;
#(
    parameter int ADDR_W       = globalAddress_width,
    parameter int DATA_W       = data_width,
    parameter int FIFO_DEPTH   = LOADER_FIFO_DEPTH,
    parameter int IDLE_TIMEOUT = LOADER_IDLE_TIMEOUT,
    parameter int RST_CYCLES   = LOADER_RST_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_gnt_i,
    output logic              cpu_hold_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              ovf_o,
    output logic [15:0]       wcount_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam logic [1:0] stIdle    = IDLE;
    localparam logic [1:0] stLoad    = LOAD;
    localparam logic [1:0] stDrain   = DRAIN;
    localparam logic [1:0] stRelease = RELEASE;

    // One timer serves both the idle timeout and the release pulse length.
    localparam int TMAX = (IDLE_TIMEOUT > RST_CYCLES) ? IDLE_TIMEOUT : RST_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    logic [1:0]               state;
    logic [TW-1:0]            timer;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     pushEn;
    logic                     popEn;
    logic                     sessionStart;
    logic [ADDR_W+DATA_W-1:0] headWord;

    assign mem_req_o    = ((state == stLoad) || (state == stDrain)) && !fifoEmpty;
    assign popEn        = mem_req_o && mem_gnt_i;
    assign pushEn       = ld_valid_i && (state != stRelease) && (!fifoFull || popEn);
    assign sessionStart = (state == stIdle) && ld_valid_i;

    assign {mem_addr_o, mem_data_o} = headWord;
    assign cpu_hold_o = (state != stIdle);
    assign busy_o     = (state != stIdle);
    assign cpu_rst_o  = (state == stRelease);

    pb_sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (pushEn),
        .pushData ({ld_addr_i, ld_data_i}),
        .pop      (popEn),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .head     (headWord)
    );

    // Session FSM: idle timeout closes LOAD, DRAIN waits for an empty FIFO, RELEASE pulses the core reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= stIdle;
            timer <= '0;
        end else begin
            case (state)
                stIdle: begin
                    if (ld_valid_i) begin
                        state <= stLoad;
                        timer <= '0;
                    end
                end
                stLoad: begin
                    if (fifoEmpty && !ld_valid_i) begin
                        if (timer == TW'(IDLE_TIMEOUT - 1)) begin
                            state <= stDrain;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else begin
                        timer <= '0;
                    end
                end
                stDrain: begin
                    if (ld_valid_i) begin
                        state <= stLoad;
                        timer <= '0;
                    end else if (fifoEmpty) begin
                        state <= stRelease;
                        timer <= '0;
                    end
                end
                stRelease: begin
                    if (timer == TW'(RST_CYCLES - 1)) begin
                        state <= stIdle;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= stIdle;
                    timer <= '0;
                end
            endcase
        end
    end

    // Sticky drop flag: any load pulse that could not be queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
        end else if (ld_valid_i && !pushEn) begin
            ovf_o <= 1'b1;
        end
    end

    // Saturating count of words accepted by memory, restarted per session.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcount_o <= '0;
        end else if (sessionStart) begin
            wcount_o <= '0;
        end else if (popEn && (wcount_o != 16'hFFFF)) begin
            wcount_o <= wcount_o + 16'd1;
        end
    end

`ifdef PB_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sumReg;

    // Wrapping sum of accepted data, restarted per session and held afterwards for readback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sumReg <= '0;
        end else if (sessionStart) begin
            sumReg <= '0;
        end else if (popEn) begin
            sumReg <= sumReg + mem_data_o;
        end
    end

    assign checksum_o = sumReg;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_pb_imem_loader.sv
// tb/tb_pb_imem_loader.sv - scoreboard bench for pb_imem_loader
module tb_pb_imem_loader;
    import pb_imem_loader_pkg::*;

    localparam int AW = globalAddress_width;
    localparam int DW = data_width;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ldValid = 1'b0;
    logic [AW-1:0] ldAddr = '0;
    logic [DW-1:0] ldData = '0;
    logic          memGnt = 1'b1;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData;
    logic          cpuHold;
    logic          cpuRst;
    logic          busy;
    logic          ovf;
    logic [15:0]   wcount;
    logic [DW-1:0] checksum;

    int errCnt = 0;
    int chkCnt = 0;

    logic [AW+DW-1:0] sbQ[$];
    logic [AW+DW-1:0] expWord;
    int               totCnt = 0;
    logic [DW-1:0]    totSum = '0;
    int               cntBase;
    logic [DW-1:0]    sumBase;

    pb_imem_loader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ld_valid_i (ldValid),
        .ld_addr_i  (ldAddr),
        .ld_data_i  (ldData),
        .mem_req_o  (memReq),
        .mem_addr_o (memAddr),
        .mem_data_o (memData),
        .mem_gnt_i  (memGnt),
        .cpu_hold_o (cpuHold),
        .cpu_rst_o  (cpuRst),
        .busy_o     (busy),
        .ovf_o      (ovf),
        .wcount_o   (wcount),
        .checksum_o (checksum)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted memory write is matched against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && memReq && memGnt) begin
            if (sbQ.size() == 0) begin
                checkVal("unexpected_write", {memAddr, memData}, 64'h0);
            end else begin
                expWord = sbQ.pop_front();
                checkVal("mem_word", {memAddr, memData}, expWord);
                totCnt++;
                totSum = totSum + expWord[DW-1:0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        ldValid = 1'b0;
        memGnt  = 1'b1;
        step();
        step();
        sbQ.delete();
        cntBase = totCnt;
        sumBase = totSum;
        rst     = 1'b0;
    endtask

    task automatic sendWord(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accepted);
        ldValid = 1'b1;
        ldAddr  = a;
        ldData  = d;
        if (accepted) sbQ.push_back({a, d});
        step();
        ldValid = 1'b0;
    endtask

    task automatic checkCounts(input string tag);
        checkVal({tag, "_wcount"}, {48'h0, wcount}, 64'(totCnt - cntBase));
`ifdef PB_LOADER_CHECKSUM_EN
        checkVal({tag, "_checksum"}, 64'(checksum), 64'(totSum - sumBase));
`else
        checkVal({tag, "_checksum"}, 64'(checksum), 64'h0);
`endif
    endtask

    // Steps until cpu_rst_o rises (dly steps), then counts how long it stays high.
    task automatic waitRelease(input string tag, output int dly, output int width);
        dly   = 0;
        width = 0;
        while (!cpuRst && dly < 300) begin
            step();
            dly++;
        end
        if (!cpuRst) begin
            checkVal({tag, "_rst_timeout"}, 64'h0, 64'h1);
            return;
        end
        while (cpuRst && width < 40) begin
            step();
            width++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dly;
        int width;
        int n;

        // Reset state
        #2;
        checkVal("rst_req",   64'(memReq),   64'h0);
        checkVal("rst_hold",  64'(cpuHold),  64'h0);
        checkVal("rst_cpurst",64'(cpuRst),   64'h0);
        checkVal("rst_busy",  64'(busy),     64'h0);
        checkVal("rst_ovf",   64'(ovf),      64'h0);
        checkVal("rst_addr",  64'(memAddr),  64'h0);
        checkVal("rst_data",  64'(memData),  64'h0);
        checkCounts("rst");
        doReset();

        // Single write: request one cycle later; 1 grant cycle + 64 idle + 1 drain before release
        sendWord(16'h0010, 32'hDEADBEEF, 1'b1);
        checkVal("t1_req",  64'(memReq),  64'h1);
        checkVal("t1_addr", 64'(memAddr), 64'h10);
        checkVal("t1_data", 64'(memData), 64'hDEADBEEF);
        checkVal("t1_hold", 64'(cpuHold), 64'h1);
        step();
        checkCounts("t1");
        waitRelease("t1", dly, width);
        checkVal("t1_rst_delay", 64'(dly),   64'(LOADER_IDLE_TIMEOUT + 1));
        checkVal("t1_rst_width", 64'(width), 64'(LOADER_RST_CYCLES));
        checkVal("t1_busy_end",  64'(busy),  64'h0);
        checkVal("t1_hold_end",  64'(cpuHold), 64'h0);
        checkCounts("t1_end");

        // Backpressure: 4 fit, 5th dropped, then drained in order
        doReset();
        memGnt = 1'b0;
        for (int i = 0; i < 4; i++) sendWord(AW'(16'h100 + i), $urandom, 1'b1);
        checkVal("t2_ovf_full", 64'(ovf),    64'h0);
        checkVal("t2_req",      64'(memReq), 64'h1);
        sendWord(16'h1FF, 32'h5555AAAA, 1'b0);
        checkVal("t2_ovf_drop", 64'(ovf),     64'h1);
        checkVal("t2_head",     64'(memAddr), 64'h100);
        memGnt = 1'b1;
        n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        checkVal("t2_drained", 64'(sbQ.size()), 64'h0);
        checkVal("t2_req_end", 64'(memReq),     64'h0);
        checkCounts("t2");

        // Full FIFO with a simultaneous pop: the new write is accepted
        doReset();
        memGnt = 1'b0;
        for (int i = 0; i < 4; i++) sendWord(AW'(16'h200 + i), $urandom, 1'b1);
        memGnt = 1'b1;
        sendWord(16'h204, 32'hCAFEF00D, 1'b1);
        checkVal("t3_ovf", 64'(ovf), 64'h0);
        n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        checkVal("t3_drained", 64'(sbQ.size()), 64'h0);
        checkCounts("t3");

        // Re-entry from DRAIN: write lands 65 steps after the first push
        doReset();
        sendWord(16'h0300, 32'h11111111, 1'b1);
        for (int i = 0; i < LOADER_IDLE_TIMEOUT + 1; i++) step();
        checkVal("t4_busy_drain", 64'(busy),   64'h1);
        checkVal("t4_rst_drain",  64'(cpuRst), 64'h0);
        sendWord(16'h0301, 32'h22222222, 1'b1);
        checkVal("t4_rst_after",  64'(cpuRst), 64'h0);
        waitRelease("t4", dly, width);
        checkVal("t4_rst_delay", 64'(dly),   64'(LOADER_IDLE_TIMEOUT + 2));
        checkVal("t4_rst_width", 64'(width), 64'(LOADER_RST_CYCLES));
        checkVal("t4_ovf",       64'(ovf),   64'h0);
        checkCounts("t4");

        // Write during RELEASE is dropped
        doReset();
        sendWord(16'h0400, 32'h0BADF00D, 1'b1);
        n = 0;
        while (!cpuRst && n < 200) begin
            step();
            n++;
        end
        checkVal("t5_rst_seen", 64'(cpuRst), 64'h1);
        sendWord(16'h0401, 32'h12345678, 1'b0);
        checkVal("t5_ovf", 64'(ovf),    64'h1);
        checkVal("t5_req", 64'(memReq), 64'h0);
        width = 1;
        while (cpuRst && width < 40) begin
            step();
            width++;
        end
        checkVal("t5_rst_width", 64'(width), 64'(LOADER_RST_CYCLES));
        checkVal("t5_busy_end",  64'(busy),  64'h0);
        checkCounts("t5");

        // Reset mid-session with 3 words queued
        doReset();
        memGnt = 1'b0;
        for (int i = 0; i < 3; i++) sendWord(AW'(16'h500 + i), $urandom, 1'b1);
        checkVal("t6_req_before", 64'(memReq), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("t6_req_async",  64'(memReq),  64'h0);
        checkVal("t6_hold_async", 64'(cpuHold), 64'h0);
        checkVal("t6_busy_async", 64'(busy),    64'h0);
        checkVal("t6_addr_async", 64'(memAddr), 64'h0);
        sbQ.delete();
        step();
        rst    = 1'b0;
        memGnt = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checkVal("t6_req_end",  64'(memReq), 64'h0);
        checkVal("t6_wcount",   64'(wcount), 64'h0);
        checkVal("t6_ovf",      64'(ovf),    64'h0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
